// File: rtl/calc_pkg.sv
// Shared encodings, widths and helpers for the calculator arithmetic sequencer.
package calc_pkg;

  // Default operand width (max operand 99) and result width (max result 9801).
  localparam int OPW_DEF  = 7;
  localparam int RESW_DEF = 14;

  // Largest legal BCD digit value.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Operation select encoding, as presented on op_sel.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Two BCD digits to a binary operand. Non-BCD digits produce a truncated
  // value that is never reported, because the error flag overrides it.
  function automatic logic [OPW_DEF-1:0] bcd_pair_to_bin(input logic [3:0] tens,
                                                         input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

  // True when a digit lies outside the BCD range.
  function automatic logic is_bad_digit(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per step, MSB first.
// After a load and exactly W steps, q holds the quotient and r the remainder.
// A zero divisor is flagged on div0; q/r are then meaningless to the caller.
module seq_divider #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         div0
);

  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] dsr_q, dsr_d;
  logic         div0_q, div0_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [W:0]   shifted;
  logic         fits;

  // Next-state: load captures operands, step performs one restoring iteration.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    div0_d  = div0_q;
    shifted = {rem_q, quo_q[W-1]};
    fits    = (shifted >= {1'b0, dsr_q});
    if (load) begin
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
      div0_d = (divisor == '0);
    end else if (step) begin
      // The quotient register doubles as the dividend shift register.
      quo_d = {quo_q[W-2:0], fits};
      // When the divisor fits the difference is below the divisor, so it
      // fits in W bits; otherwise shifted is below the divisor and its MSB is 0.
      rem_d = fits ? W'(shifted - {1'b0, dsr_q}) : shifted[W-1:0];
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      div0_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      div0_q <= div0_d;
    end
  end

  assign q    = quo_q;
  assign r    = rem_q;
  assign div0 = div0_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle arithmetic sequencer for the calculator: captures two 2-digit
// BCD operands and an operation on start, runs ADD/SUB/MUL in one cycle or DIV
// through an iterative divider, and publishes a registered result with done.
//
// Handshake: start is a one-cycle request that is accepted only while busy is
// low (IDLE); it is never queued. busy is high from the accepting edge until
// the edge that raises done. done is a one-cycle pulse marking the edge where
// result/remainder/negsign/err were updated; those outputs then hold until the
// next done or reset. A start coinciding with done is accepted.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int OPW  = OPW_DEF,
  parameter int RESW = RESW_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [3:0]      dig0,
  input  logic [3:0]      dig1,
  input  logic [3:0]      dig2,
  input  logic [3:0]      dig3,
  input  logic [1:0]      op_sel,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [RESW-1:0] result,
  output logic [OPW-1:0]  remainder,
  output logic            negsign,
  output logic            err
);

  localparam int CNT_W = $clog2(OPW);

  state_e state_q, state_d;

  // Captured operation context, held until the next accepted start.
  logic [OPW-1:0]  num1_q, num1_d;
  logic [OPW-1:0]  num2_q, num2_d;
  op_e             op_q, op_d;
  logic            bad_q, bad_d;

  // Single-cycle ALU result staged between EXEC and FINISH.
  logic [RESW-1:0] res_q, res_d;
  logic            neg_q, neg_d;

  // Divider step counter.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Published outputs.
  logic [RESW-1:0] result_q, result_d;
  logic [OPW-1:0]  remainder_q, remainder_d;
  logic            negsign_q, negsign_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  // Operands formed directly from the digit inputs.
  logic [OPW-1:0]  num1_in, num2_in;
  logic            bad_in;

  // Divider control and outputs.
  logic            div_load, div_step;
  logic [OPW-1:0]  div_quo, div_rem;
  logic            div_zero;

  // Digit decode used at capture time.
  always_comb begin
    num1_in = bcd_pair_to_bin(dig3, dig2);
    num2_in = bcd_pair_to_bin(dig1, dig0);
    bad_in  = is_bad_digit(dig0) | is_bad_digit(dig1) |
              is_bad_digit(dig2) | is_bad_digit(dig3);
  end

  // The divider is loaded on the accepting edge straight from the digits so
  // its first step can happen on the very next edge.
  seq_divider #(.W(OPW)) u_div (
    .clk      (clk_in),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (num1_in),
    .divisor  (num2_in),
    .q        (div_quo),
    .r        (div_rem),
    .div0     (div_zero)
  );

  // Next-state, datapath and output-update logic for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    op_d        = op_q;
    bad_d       = bad_q;
    res_d       = res_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    negsign_d   = negsign_q;
    err_d       = err_q;
    done_d      = 1'b0;
    div_load    = 1'b0;
    div_step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num1_d   = num1_in;
          num2_d   = num2_in;
          op_d     = op_e'(op_sel);
          bad_d    = bad_in;
          cnt_d    = '0;
          div_load = (op_e'(op_sel) == OP_DIV);
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op_q == OP_DIV) begin
          // One quotient bit per edge; leave after the OPW-th step.
          div_step = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(OPW - 1)) begin
            state_d = ST_FINISH;
          end
        end else begin
          neg_d = 1'b0;
          case (op_q)
            OP_ADD: res_d = RESW'(num1_q) + RESW'(num2_q);
            OP_SUB: begin
              if (num1_q < num2_q) begin
                res_d = RESW'(num2_q - num1_q);
                neg_d = 1'b1;
              end else begin
                res_d = RESW'(num1_q - num2_q);
              end
            end
            default: res_d = RESW'(num1_q) * RESW'(num2_q);
          endcase
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (bad_q || ((op_q == OP_DIV) && div_zero)) begin
          result_d    = '0;
          remainder_d = '0;
          negsign_d   = 1'b0;
          err_d       = 1'b1;
        end else if (op_q == OP_DIV) begin
          result_d    = RESW'(div_quo);
          remainder_d = div_rem;
          negsign_d   = 1'b0;
          err_d       = 1'b0;
        end else begin
          result_d    = res_q;
          remainder_d = '0;
          negsign_d   = neg_q;
          err_d       = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num1_q      <= '0;
      num2_q      <= '0;
      op_q        <= OP_ADD;
      bad_q       <= 1'b0;
      res_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      negsign_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      op_q        <= op_d;
      bad_q       <= bad_d;
      res_q       <= res_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      negsign_q   <= negsign_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign negsign   = negsign_q;
  assign err       = err_q;

endmodule
